// File: rtl/xy_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xy_dac_pkg
//  Brief    : Shared types and constants for the X/Y DAC arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package xy_dac_pkg;

    localparam int c_DAC_W = 8;

    // One-hot owner encoding as seen on the grant output.
    localparam logic [1:0] c_OWNER_NONE = 2'b00;
    localparam logic [1:0] c_OWNER_0    = 2'b01;
    localparam logic [1:0] c_OWNER_1    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRAW  = 2'd2
    } state_t;

endpackage : xy_dac_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin pick; a tie goes to the source that did not
//             own the DAC last.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import xy_dac_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_owner,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_last_owner ? c_OWNER_0 : c_OWNER_1;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/xy_dac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xy_dac_arbiter
//  Brief    : Burst-granting arbiter sharing one X/Y DAC pair between two
//             sample sources, with hand-over blanking and per-sample dwell.
//  Revision : 1.0  initial release
// ============================================================================
module xy_dac_arbiter
    import xy_dac_pkg::*;
#(
    parameter int DAC_W         = c_DAC_W,
    parameter int DWELL_W       = 8,
    parameter int BLANK_W       = 4,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [DAC_W-1:0]   req0_x,
    input  logic [DAC_W-1:0]   req0_y,
    input  logic               req0_last,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DAC_W-1:0]   req1_x,
    input  logic [DAC_W-1:0]   req1_y,
    input  logic               req1_last,
    output logic               req1_ready,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [BLANK_W-1:0] cfg_blank,
    output logic [DAC_W-1:0]   xdac,
    output logic [DAC_W-1:0]   ydac,
    output logic               blank,
    output logic [1:0]         grant,
    output logic               busy
);

    localparam int c_STALL_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;

    state_t               r_state;
    logic [1:0]           r_grant;
    logic                 r_last_owner;
    logic [BLANK_W-1:0]   r_blank_cnt;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_done_pending;

    logic [1:0]           w_valid;
    logic [1:0]           w_pick;
    logic                 w_draw_idle;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic [DAC_W-1:0]     w_own_x;
    logic [DAC_W-1:0]     w_own_y;
    logic                 w_stall_end;

    assign w_valid = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .i_valid      (w_valid),
        .i_last_owner (r_last_owner),
        .o_grant      (w_pick)
    );

    // Ready depends only on registered state, so a source can never create a
    // combinational loop by making valid wait on ready.
    assign w_draw_idle = (r_state == DRAW) && (r_dwell_cnt == '0) && !r_done_pending;
    assign req0_ready  = w_draw_idle && r_grant[0];
    assign req1_ready  = w_draw_idle && r_grant[1];

    assign w_own_valid = r_grant[1] ? req1_valid : req0_valid;
    assign w_own_last  = r_grant[1] ? req1_last  : req0_last;
    assign w_own_x     = r_grant[1] ? req1_x     : req0_x;
    assign w_own_y     = r_grant[1] ? req1_y     : req0_y;
    assign w_stall_end = (r_stall_cnt == c_STALL_W'(STALL_TIMEOUT - 1));

    assign grant = r_grant;
    assign busy  = |r_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_grant        <= c_OWNER_NONE;
            r_last_owner   <= 1'b1;
            r_blank_cnt    <= '0;
            r_dwell_cnt    <= '0;
            r_stall_cnt    <= '0;
            r_done_pending <= 1'b0;
            xdac           <= '0;
            ydac           <= '0;
            blank          <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    blank <= 1'b1;
                    if (|w_valid) begin
                        r_grant        <= w_pick;
                        r_blank_cnt    <= cfg_blank;
                        r_dwell_cnt    <= '0;
                        r_stall_cnt    <= '0;
                        r_done_pending <= 1'b0;
                        r_state        <= (cfg_blank == '0) ? DRAW : BLANK;
                    end
                end
                BLANK: begin
                    if (r_blank_cnt <= BLANK_W'(1)) begin
                        r_state <= DRAW;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - BLANK_W'(1);
                    end
                end
                DRAW: begin
                    if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end else if (r_done_pending || (!w_own_valid && w_stall_end)) begin
                        r_state        <= IDLE;
                        r_last_owner   <= r_grant[1];
                        r_grant        <= c_OWNER_NONE;
                        r_done_pending <= 1'b0;
                        blank          <= 1'b1;
                    end else if (w_own_valid) begin
                        xdac           <= w_own_x;
                        ydac           <= w_own_y;
                        blank          <= 1'b0;
                        r_dwell_cnt    <= cfg_dwell;
                        r_stall_cnt    <= '0;
                        r_done_pending <= w_own_last;
                    end else begin
                        blank       <= 1'b1;
                        r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= c_OWNER_NONE;
                    blank   <= 1'b1;
                end
            endcase
        end
    end

endmodule : xy_dac_arbiter
`default_nettype wire

// File: tb/tb_xy_dac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xy_dac_arbiter
//  Brief    : Directed self-checking bench for xy_dac_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xy_dac_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_x, req0_y, req1_x, req1_y;
    logic [7:0] cfg_dwell;
    logic [3:0] cfg_blank;
    logic [7:0] xdac, ydac;
    logic       blank, busy;
    logic [1:0] grant;

    int n_checks = 0;
    int n_pass   = 0;

    // Source models: sample i is (bx+i, by+i); last on n-1; valid only while idx < stop.
    int s0_bx, s0_by, s0_n, s0_stop, s0_idx;
    int s1_bx, s1_by, s1_n, s1_stop, s1_idx;
    bit s0_en = 1'b0, s1_en = 1'b0;

    always #5 clk = ~clk;

    xy_dac_arbiter #(
        .DAC_W(8), .DWELL_W(8), .BLANK_W(4), .STALL_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
        .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
        .req1_last(req1_last), .req1_ready(req1_ready),
        .cfg_dwell(cfg_dwell), .cfg_blank(cfg_blank),
        .xdac(xdac), .ydac(ydac), .blank(blank), .grant(grant), .busy(busy)
    );

    task automatic drive_srcs();
        req0_valid = s0_en && (s0_idx < s0_stop);
        req0_x     = 8'(s0_bx + s0_idx);
        req0_y     = 8'(s0_by + s0_idx);
        req0_last  = (s0_idx == s0_n - 1);
        req1_valid = s1_en && (s1_idx < s1_stop);
        req1_x     = 8'(s1_bx + s1_idx);
        req1_y     = 8'(s1_by + s1_idx);
        req1_last  = (s1_idx == s1_n - 1);
    endtask

    task automatic start0(input int bx, input int by, input int n, input int stop);
        s0_bx = bx; s0_by = by; s0_n = n; s0_stop = stop; s0_idx = 0; s0_en = 1'b1;
        drive_srcs();
    endtask

    task automatic start1(input int bx, input int by, input int n, input int stop);
        s1_bx = bx; s1_by = by; s1_n = n; s1_stop = stop; s1_idx = 0; s1_en = 1'b1;
        drive_srcs();
    endtask

    // Called at a negedge; advances one clock and returns at the next negedge.
    task automatic tick(output bit acc0, output bit acc1);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (acc0) s0_idx++;
        if (acc1) s1_idx++;
        if (s0_idx >= s0_n) s0_en = 1'b0;
        if (s1_idx >= s1_n) s1_en = 1'b0;
        drive_srcs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        s0_en = 1'b0; s1_en = 1'b0; s0_idx = 0; s1_idx = 0;
        drive_srcs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit a0, a1;
        s0_en = 1'b0; s1_en = 1'b0; s0_idx = 0; s1_idx = 0; s0_n = 1; s1_n = 1;
        drive_srcs();
        cfg_dwell = 8'd0; cfg_blank = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (xdac !== 8'd0 || ydac !== 8'd0) $display("FAIL reset_xy: got %0d,%0d want 0,0", xdac, ydac); else n_pass++;
        n_checks++; if (blank !== 1'b1) $display("FAIL reset_blank: got %b want 1", blank); else n_pass++;
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL reset_grant: got %b/%b want 00/0", grant, busy); else n_pass++;
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready); else n_pass++;
        reset = 1'b0;
        tick(a0, a1);
        n_checks++; if (grant !== 2'b00) $display("FAIL idle_no_req: got %b want 00", grant); else n_pass++;
    endtask

    task automatic test_single();
        bit a0, a1;
        cfg_dwell = 8'd0; cfg_blank = 4'd2;
        start0(10, 20, 4, 4);
        tick(a0, a1);
        n_checks++; if (grant !== 2'b01 || busy !== 1'b1) $display("FAIL single_grant: got %b/%b want 01/1", grant, busy); else n_pass++;
        n_checks++; if (blank !== 1'b1 || req0_ready !== 1'b0) $display("FAIL single_blank1: blank %b ready %b want 1/0", blank, req0_ready); else n_pass++;
        tick(a0, a1);
        n_checks++; if (blank !== 1'b1 || req0_ready !== 1'b0) $display("FAIL single_blank2: blank %b ready %b want 1/0", blank, req0_ready); else n_pass++;
        tick(a0, a1);
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL single_draw_ready: got %b want 1", req0_ready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick(a0, a1);
            n_checks++; if (a0 !== 1'b1) $display("FAIL single_accept%0d: got %b want 1", i, a0); else n_pass++;
            n_checks++; if (xdac !== 8'(10 + i) || ydac !== 8'(20 + i) || blank !== 1'b0)
                $display("FAIL single_out%0d: got %0d,%0d,%b want %0d,%0d,0", i, xdac, ydac, blank, 10 + i, 20 + i); else n_pass++;
        end
        tick(a0, a1);
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0 || blank !== 1'b1)
            $display("FAIL single_end: grant %b busy %b blank %b want 00/0/1", grant, busy, blank); else n_pass++;
        n_checks++; if (xdac !== 8'd13 || ydac !== 8'd23) $display("FAIL single_hold: got %0d,%0d want 13,23", xdac, ydac); else n_pass++;
    endtask

    task automatic test_dwell();
        bit a0, a1;
        cfg_dwell = 8'd3; cfg_blank = 4'd0;
        start1(40, 50, 3, 3);
        tick(a0, a1);
        n_checks++; if (grant !== 2'b10 || req1_ready !== 1'b1) $display("FAIL dwell_grant: grant %b ready %b want 10/1", grant, req1_ready); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick(a0, a1);
                n_checks++; if (a1 !== (c == 0)) $display("FAIL dwell_acc k%0d c%0d: got %b want %b", k, c, a1, c == 0); else n_pass++;
                n_checks++; if (xdac !== 8'(40 + k) || ydac !== 8'(50 + k) || blank !== 1'b0)
                    $display("FAIL dwell_hold k%0d c%0d: got %0d,%0d,%b want %0d,%0d,0", k, c, xdac, ydac, blank, 40 + k, 50 + k); else n_pass++;
            end
        end
        n_checks++; if (req1_ready !== 1'b0) $display("FAIL dwell_done_ready: got %b want 0", req1_ready); else n_pass++;
        tick(a0, a1);
        n_checks++; if (grant !== 2'b00 || blank !== 1'b1) $display("FAIL dwell_end: grant %b blank %b want 00/1", grant, blank); else n_pass++;
    endtask

    task automatic test_contention();
        bit a0, a1;
        int exp_s[$];
        int exp_x[$];
        int es, ex, c;
        do_reset();
        cfg_dwell = 8'd0; cfg_blank = 4'd1;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                start0(60, 70, 3, 3); start1(80, 90, 2, 2);
                exp_s = '{0, 0, 0, 1, 1}; exp_x = '{60, 61, 62, 80, 81};
            end else begin
                start0(100, 110, 2, 2); start1(120, 130, 2, 2);
                exp_s = '{0, 0, 1, 1}; exp_x = '{100, 101, 120, 121};
            end
            c = 0;
            while (c < 60 && !(exp_s.size() == 0 && grant == 2'b00)) begin
                if (grant == 2'b01) begin
                    n_checks++; if (req1_ready !== 1'b0) $display("FAIL cont_r%0d_ready1: got %b want 0", r, req1_ready); else n_pass++;
                end
                tick(a0, a1);
                if (a0 || a1) begin
                    n_checks++;
                    if (exp_s.size() == 0) $display("FAIL cont_r%0d_extra: got accept want none", r);
                    else begin
                        es = exp_s.pop_front(); ex = exp_x.pop_front();
                        if ((a1 ? 1 : 0) !== es || a0 === a1 || xdac !== 8'(ex) || ydac !== 8'(ex + 10))
                            $display("FAIL cont_r%0d_order: got src %0d x %0d y %0d want src %0d x %0d y %0d",
                                     r, a1 ? 1 : 0, xdac, ydac, es, ex, ex + 10);
                        else n_pass++;
                    end
                end
                c++;
            end
            n_checks++; if (exp_s.size() != 0 || grant !== 2'b00)
                $display("FAIL cont_r%0d_timeout: got %0d left grant %b want 0 left grant 00", r, exp_s.size(), grant); else n_pass++;
        end
    endtask

    task automatic test_starvation();
        bit a0, a1;
        cfg_dwell = 8'd0; cfg_blank = 4'd0;
        start0(30, 31, 5, 1); start1(90, 91, 1, 1);
        tick(a0, a1);
        n_checks++; if (grant !== 2'b01) $display("FAIL starve_grant: got %b want 01", grant); else n_pass++;
        tick(a0, a1);
        n_checks++; if (a0 !== 1'b1 || xdac !== 8'd30 || blank !== 1'b0)
            $display("FAIL starve_first: acc %b x %0d blank %b want 1/30/0", a0, xdac, blank); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            n_checks++; if (req1_ready !== 1'b0) $display("FAIL starve_ready1_%0d: got %b want 0", k, req1_ready); else n_pass++;
            tick(a0, a1);
            n_checks++; if (blank !== 1'b1 || xdac !== 8'd30) $display("FAIL starve_blank%0d: blank %b x %0d want 1/30", k, blank, xdac); else n_pass++;
            n_checks++; if (grant !== ((k < 8) ? 2'b01 : 2'b00)) $display("FAIL starve_grant%0d: got %b want %b", k, grant, (k < 8) ? 2'b01 : 2'b00); else n_pass++;
        end
        s0_en = 1'b0; drive_srcs();
        tick(a0, a1);
        n_checks++; if (grant !== 2'b10) $display("FAIL starve_handover: got %b want 10", grant); else n_pass++;
        tick(a0, a1);
        n_checks++; if (a1 !== 1'b1 || xdac !== 8'd90 || ydac !== 8'd91) $display("FAIL starve_req1: acc %b got %0d,%0d want 1/90,91", a1, xdac, ydac); else n_pass++;
        tick(a0, a1);
        n_checks++; if (grant !== 2'b00) $display("FAIL starve_end: got %b want 00", grant); else n_pass++;
    endtask

    task automatic test_zero_blank();
        bit a0, a1;
        cfg_dwell = 8'd0; cfg_blank = 4'd0;
        start0(5, 6, 1, 1);
        tick(a0, a1);
        n_checks++; if (grant !== 2'b01 || blank !== 1'b1 || req0_ready !== 1'b1)
            $display("FAIL zb_grant: grant %b blank %b ready %b want 01/1/1", grant, blank, req0_ready); else n_pass++;
        tick(a0, a1);
        n_checks++; if (a0 !== 1'b1 || xdac !== 8'd5 || ydac !== 8'd6 || blank !== 1'b0)
            $display("FAIL zb_accept: acc %b got %0d,%0d,%b want 1/5,6,0", a0, xdac, ydac, blank); else n_pass++;
        tick(a0, a1);
        n_checks++; if (grant !== 2'b00) $display("FAIL zb_end: got %b want 00", grant); else n_pass++;
    endtask

    task automatic test_reset_mid_draw();
        bit a0, a1;
        cfg_dwell = 8'd0; cfg_blank = 4'd0;
        start0(7, 8, 4, 4);
        tick(a0, a1);
        tick(a0, a1);
        n_checks++; if (blank !== 1'b0 || xdac !== 8'd7) $display("FAIL mid_pre: blank %b x %0d want 0/7", blank, xdac); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (xdac !== 8'd0 || ydac !== 8'd0 || blank !== 1'b1 || grant !== 2'b00 || busy !== 1'b0 || req0_ready !== 1'b0)
            $display("FAIL mid_reset: got %0d,%0d blank %b grant %b busy %b ready %b want 0,0/1/00/0/0",
                     xdac, ydac, blank, grant, busy, req0_ready); else n_pass++;
        s0_en = 1'b0; drive_srcs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dwell();
        test_contention();
        test_starvation();
        test_zero_blank();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_xy_dac_arbiter
`default_nettype wire
